// File: rtl/alu_pkg.sv
// Shared ALU types and constants.
// Used by the sequential multiplier and its step datapath.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ADDC,
    S_DONE
  } mult_state_t;

endpackage

// File: rtl/mult_step.sv
// One RUN cycle of the shift-add multiplier.
// Retires BPC multiplier bits from the low end of P.
module mult_step #(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0]   rn_i,
  output logic [2*WIDTH-1:0] p_o
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p;

  // The second retired bit sees Rn one place higher because P
  // has already shifted once.
  always_comb begin
    sum = '0;
    p   = p_i;
    for (int i = 0; i < BPC; i++) begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]}
          + (p[0] ? {1'b0, rn_i} : '0);
      p   = {sum, p[WIDTH-1:1]};
    end
    p_o = p;
  end

endmodule

// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned shift-add multiplier fed by the ALU decoder.
// Product plus carry-in is returned after WIDTH/BPC + 2 cycles.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH          = ALU_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             START,
  input  logic [WIDTH-1:0] Rn,
  input  logic [WIDTH-1:0] Rm,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT_LO,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             COUT
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(STEPS - 1);

  mult_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rn_q, rn_d;
  logic               cin_q, cin_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               cout_q, cout_d;

  logic [2*WIDTH-1:0] p_step;
  logic [2*WIDTH-1:0] p_addc;
  logic               accept;

  mult_step #(
    .WIDTH (WIDTH),
    .BPC   (BITS_PER_CYCLE)
  ) u_step (
    .p_i  (p_q),
    .rn_i (rn_q),
    .p_o  (p_step)
  );

  assign accept = START
    && (state_q == S_IDLE || state_q == S_DONE);
  assign p_addc = p_q + {{(2*WIDTH-1){1'b0}}, cin_q};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rn_q    <= '0;
      cin_q   <= 1'b0;
      p_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rn_q    <= rn_d;
      cin_q   <= cin_d;
      p_q     <= p_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (START) state_d = S_RUN;
      S_RUN:  if (cnt_q == '0) state_d = S_ADDC;
      S_ADDC: state_d = S_DONE;
      S_DONE: state_d = START ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are only captured on an accepted issue, so START
  // while busy leaves every register untouched.
  always_comb begin
    cnt_d  = cnt_q;
    rn_d   = rn_q;
    cin_d  = cin_q;
    p_d    = p_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    cout_d = cout_q;
    if (accept) begin
      rn_d  = Rn;
      cin_d = CIN;
      p_d   = {{WIDTH{1'b0}}, Rm};
      cnt_d = CNT_INIT;
    end else if (state_q == S_RUN) begin
      p_d = p_step;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else if (state_q == S_ADDC) begin
      p_d    = p_addc;
      lo_d   = p_addc[WIDTH-1:0];
      hi_d   = p_addc[2*WIDTH-1:WIDTH];
      cout_d = |p_addc[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    BUSY      = (state_q == S_RUN) || (state_q == S_ADDC);
    DONE      = (state_q == S_DONE);
    RESULT_LO = lo_q;
    RESULT_HI = hi_q;
    COUT      = cout_q;
  end

endmodule
